imem_loader: RTL and testbench

- Boot-time writer for the instruction memory.
- Accepts a byte stream through a valid/ready handshake, assembles little-endian 32-bit words, and drives the memory's write port (address, write data, write enable) one word at a time.
- Holds the CPU in reset until a complete image has been written.
- Sits between the host/debug byte source (UART receiver or testbench) and the instruction memory write port.

---
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed little-endian byte
// stream and writes it word by word, holding the CPU in reset until the image is complete.
module imem_loader #(
  parameter int          SIZE      = 2048,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold,
  output logic [31:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [31:0] SIZE_W = 32'(SIZE);

  state_t      state;
  state_t      next_state;
  logic [1:0]  byte_cnt;
  logic [31:0] len_reg;
  logic [31:0] word_reg;
  logic        accept;
  logic        last_byte;
  logic [31:0] len_next;
  logic [31:0] word_next;
  logic [31:0] count_next;

  // Handshake: a byte moves on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  assign in_ready   = (state == S_LEN) || (state == S_DATA);
  assign accept     = in_valid && in_ready;
  assign last_byte  = accept && (byte_cnt == 2'd3);
  assign len_next   = {in_data, len_reg[31:8]};
  assign word_next  = {in_data, word_reg[31:8]};
  assign count_next = words_loaded + 32'd1;

  assign busy     = (state == S_LEN) || (state == S_DATA) || (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign cpu_hold = (state != S_DONE);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_LEN;
      S_LEN: begin
        if (last_byte) begin
          if (len_next == 32'd0)       next_state = S_DONE;
          else if (len_next > SIZE_W)  next_state = S_ERR;
          else                         next_state = S_DATA;
        end
      end
      S_DATA:  if (last_byte) next_state = S_WRITE;
      S_WRITE: next_state = (count_next == len_reg) ? S_DONE : S_DATA;
      S_DONE:  if (start) next_state = S_LEN;
      S_ERR:   if (start) next_state = S_LEN;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      byte_cnt     <= 2'd0;
      len_reg      <= 32'd0;
      word_reg     <= 32'd0;
      words_loaded <= 32'd0;
      mem_a        <= BASE_ADDR;
      mem_wd       <= 32'd0;
      mem_we       <= 1'b0;
    end else begin
      state  <= next_state;
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            byte_cnt     <= 2'd0;
            len_reg      <= 32'd0;
            words_loaded <= 32'd0;
          end
        end
        S_LEN: begin
          if (accept) begin
            len_reg  <= len_next;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (accept) begin
            word_reg <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
          end
          // Write port is registered so it is stable for the whole WRITE cycle.
          if (last_byte) begin
            mem_we <= 1'b1;
            mem_a  <= BASE_ADDR + {words_loaded[29:0], 2'b00};
            mem_wd <= word_next;
          end
        end
        S_WRITE: words_loaded <= count_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: driver tasks feed byte images, a monitor
// compares every memory write against the expected queue.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;
  logic [31:0] words_loaded;

  imem_loader #(.SIZE(2048), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .busy(busy),
    .done(done), .error(error), .cpu_hold(cpu_hold), .words_loaded(words_loaded)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [63:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          nwrites = 0;
  logic [31:0] last_a = '0;
  logic        prev_we = 1'b0;
  int          acc_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      check("we_single_cycle", 64'(prev_we), 64'd0);
      check("we_not_with_ready", 64'(in_ready), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: a=0x%0h wd=0x%0h with empty queue", mem_a, mem_wd);
      end else begin
        check("write_a_wd", {mem_a, mem_wd}, exp_q.pop_front());
      end
      last_a = mem_a;
      nwrites++;
    end
    prev_we = rst_n && mem_we;
  end

  // Driver tasks (all called and returning at a falling edge)
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    guard = 0;
    if (stall) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("byte_accept_timeout", 64'(guard), 64'd0);
    end else begin
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_low", 64'(done), 64'd0);
    check("start_hold", 64'(cpu_hold), 64'd1);
  endtask

  task automatic wait_end(output int at);
    int g;
    g = 0;
    while (!done && !error && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("end_timeout", 64'(g), 64'd0);
    at = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_a"}, 64'(mem_a), 64'(BASE));
    check({tag, "_mem_wd"}, 64'(mem_wd), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  task automatic load_words(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input bit stall);
    logic [31:0] w;
    send_word(32'(n), stall);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : (i == 1) ? w1 : w2;
      exp_q.push_back({BASE + 32'(4 * i), w});
      send_word(w, stall);
    end
    in_valid = 1'b0;
  endtask

  // Main sequence
  initial begin
    int first_acc;
    int t_end;
    int w_before;
    logic [31:0] w;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_no_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;

    // Basic load with in_valid held high
    pulse_start();
    send_byte(8'h02, 1'b0);
    first_acc = acc_cyc;
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    exp_q.push_back({32'h0000_0000, 32'h0000_0013});
    send_word(32'h0000_0013, 1'b0);
    exp_q.push_back({32'h0000_0004, 32'h0010_0093});
    send_word(32'h0010_0093, 1'b0);
    in_valid = 1'b0;
    wait_end(t_end);
    check("basic_latency", 64'(t_end - first_acc), 64'd13);
    check("basic_done", 64'(done), 64'd1);
    check("basic_hold", 64'(cpu_hold), 64'd0);
    check("basic_busy", 64'(busy), 64'd0);
    check("basic_words", 64'(words_loaded), 64'd2);
    check("basic_drained", 64'(exp_q.size()), 64'd0);

    // Back-pressure: same image, random gaps in in_valid
    pulse_start();
    load_words(2, 32'h0000_0013, 32'h0010_0093, 32'h0, 1'b1);
    wait_end(t_end);
    check("bp_done", 64'(done), 64'd1);
    check("bp_words", 64'(words_loaded), 64'd2);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // N = 0
    w_before = nwrites;
    pulse_start();
    load_words(0, 32'h0, 32'h0, 32'h0, 1'b0);
    wait_end(t_end);
    check("n0_done", 64'(done), 64'd1);
    check("n0_words", 64'(words_loaded), 64'd0);
    check("n0_no_write", 64'(nwrites - w_before), 64'd0);

    // N = SIZE + 1 is rejected
    pulse_start();
    send_word(32'h0000_0801, 1'b0);
    wait_end(t_end);
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_done", 64'(done), 64'd0);
    check("ovf_hold", 64'(cpu_hold), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("ovf_no_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check("ovf_no_write", 64'(nwrites - w_before), 64'd0);

    // Recovery with N = 1
    pulse_start();
    check("recover_error_clear", 64'(error), 64'd0);
    load_words(1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);
    wait_end(t_end);
    check("n1_done", 64'(done), 64'd1);
    check("n1_words", 64'(words_loaded), 64'd1);

    // Full image: 2048 words
    pulse_start();
    send_word(32'd2048, 1'b0);
    for (int i = 0; i < 2048; i++) begin
      w = {i[15:0], ~i[15:0]};
      exp_q.push_back({BASE + 32'(4 * i), w});
      send_word(w, 1'b0);
    end
    in_valid = 1'b0;
    wait_end(t_end);
    check("full_done", 64'(done), 64'd1);
    check("full_words", 64'(words_loaded), 64'd2048);
    check("full_last_a", 64'(last_a), 64'(BASE + 32'h1FFC));
    check("full_drained", 64'(exp_q.size()), 64'd0);

    // Reset after 2 of 3 words plus one byte
    pulse_start();
    send_word(32'd3, 1'b0);
    exp_q.push_back({BASE, 32'h1111_2222});
    send_word(32'h1111_2222, 1'b0);
    exp_q.push_back({BASE + 32'd4, 32'h3333_4444});
    send_word(32'h3333_4444, 1'b0);
    send_byte(8'h77, 1'b0);
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    in_valid = 1'b0;
    check("midrst_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    load_words(3, 32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 1'b0);
    wait_end(t_end);
    check("reload_done", 64'(done), 64'd1);
    check("reload_words", 64'(words_loaded), 64'd3);
    check("reload_last_a", 64'(last_a), 64'(BASE + 32'd8));

    repeat (3) @(negedge clk);
    check("final_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
